spi_slave_byte_if: RTL and testbench

SPI mode-0 responder byte engine running entirely in the system clock domain.
- Oversamples SCLK/MOSI/SS_n from an external SPI master, deserialises MOSI into bytes and serialises a user-supplied byte onto MISO.
- Sits opposite the existing SPI master, as the slave-side endpoint that user logic talks to through a one-byte TX buffer and an RX strobe.

---
 rtl/spi_slave_byte_if.sv | 178 +++++++++++++++++
 tb/tb_spi_slave_byte_if.sv | 220 ++++++++++++++++++++++
 2 files changed

// File: rtl/spi_slave_byte_if.sv
// spi_slave_byte_if
// SPI mode-0 (CPOL=0, CPHA=0, MSB first) slave byte engine that runs entirely
// in the system clock domain. SCLK, MOSI and SS_n are oversampled through
// synchroniser chains. Received bytes are presented on rx_data with a
// one-clock rx_done strobe. The byte to transmit comes from a single-entry
// TX buffer that user logic fills through a valid/ready handshake.
//
// Parameters:
//   SYNC_STAGES  synchroniser depth for sclk/mosi/ss_n (>= 2)
//   DUMMY_BYTE   byte sent on MISO when the TX buffer is empty at byte start
//
// Ports:
//   clk, rst            system clock, synchronous active-high reset
//   sclk, mosi, ss_n    SPI lines from the master (asynchronous to clk)
//   miso                SPI data back to the master
//   tx_data, tx_valid   byte offered for the next SPI byte
//   tx_ready            TX buffer empty (write accepted when valid && ready)
//   rx_data, rx_done    last complete received byte, one-clock update strobe
//   busy                slave select active (synchronised, registered)
//
// Optional feature, enabled by defining SPI_SLAVE_FRAME_ERR_EN:
//   frame_err    one-clock pulse when ss_n rises in the middle of a byte
//   tx_underrun  one-clock pulse when a byte starts with DUMMY_BYTE
module spi_slave_byte_if #(
    parameter int         SYNC_STAGES = 2,
    parameter logic [7:0] DUMMY_BYTE  = 8'hFF
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       sclk,
    input  logic       mosi,
    input  logic       ss_n,
    output logic       miso,
    input  logic [7:0] tx_data,
    input  logic       tx_valid,
    output logic       tx_ready,
    output logic [7:0] rx_data,
    output logic       rx_done,
    output logic       busy
`ifdef SPI_SLAVE_FRAME_ERR_EN
    ,
    output logic       frame_err,
    output logic       tx_underrun
`endif
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        LOAD  = 2'd1,
        SHIFT = 2'd2
    } state_t;

    state_t state, state_nxt;

    logic [SYNC_STAGES-1:0] sclk_sync;
    logic [SYNC_STAGES-1:0] mosi_sync;
    logic [SYNC_STAGES-1:0] ss_n_sync;
    logic                   sclk_p1;
    logic                   ss_n_p1;

    logic       sclk_s, mosi_s, ss_n_s;
    logic       sclk_rise, sclk_fall, ss_rise, ss_fall;
    logic       shift_rise, shift_fall, load_en, tx_wr;

    logic [2:0] bit_cnt;
    logic       full;
    logic [7:0] tx_buf;
    logic [7:0] tx_shift;
    logic [7:0] rx_shift;

    // ---- Stage 0: input synchronisers and one-clock edge history ----
    always_ff @(posedge clk) begin
        if (rst) begin
            sclk_sync <= '0;
            mosi_sync <= '0;
            ss_n_sync <= '1;
            sclk_p1   <= 1'b0;
            ss_n_p1   <= 1'b1;
        end else begin
            sclk_sync <= {sclk_sync[SYNC_STAGES-2:0], sclk};
            mosi_sync <= {mosi_sync[SYNC_STAGES-2:0], mosi};
            ss_n_sync <= {ss_n_sync[SYNC_STAGES-2:0], ss_n};
            sclk_p1   <= sclk_sync[SYNC_STAGES-1];
            ss_n_p1   <= ss_n_sync[SYNC_STAGES-1];
        end
    end

    assign sclk_s    = sclk_sync[SYNC_STAGES-1];
    assign mosi_s    = mosi_sync[SYNC_STAGES-1];
    assign ss_n_s    = ss_n_sync[SYNC_STAGES-1];
    assign sclk_rise = sclk_s & ~sclk_p1;
    assign sclk_fall = ~sclk_s & sclk_p1;
    assign ss_rise   = ss_n_s & ~ss_n_p1;
    assign ss_fall   = ~ss_n_s & ss_n_p1;

    // Deselect takes priority over any SCLK edge seen in the same cycle.
    assign shift_rise = (state == SHIFT) && sclk_rise && !ss_rise;
    assign shift_fall = (state == SHIFT) && sclk_fall && !ss_rise;
    assign load_en    = (state == LOAD) && !ss_rise;
    assign tx_wr      = tx_valid && !full;

    assign tx_ready = !full;
    assign miso     = (state == SHIFT) && tx_shift[7];

    always_comb begin
        state_nxt = state;
        if (ss_rise) begin
            state_nxt = IDLE;
        end else begin
            case (state)
                IDLE:    if (ss_fall) state_nxt = LOAD;
                LOAD:    state_nxt = SHIFT;
                SHIFT:   if (sclk_fall && bit_cnt == 3'd0) state_nxt = LOAD;
                default: state_nxt = IDLE;
            endcase
        end
    end

    // ---- Stage 1: control state, counters and strobes ----
    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= IDLE;
            bit_cnt <= 3'd0;
            full    <= 1'b0;
            rx_data <= 8'h00;
            rx_done <= 1'b0;
            busy    <= 1'b0;
        end else begin
            state   <= state_nxt;
            busy    <= ~ss_n_s;
            rx_done <= 1'b0;
            if (ss_rise || load_en) begin
                bit_cnt <= 3'd0;
            end else if (shift_rise) begin
                bit_cnt <= bit_cnt + 3'd1;
                if (bit_cnt == 3'd7) begin
                    rx_data <= {rx_shift[6:0], mosi_s};
                    rx_done <= 1'b1;
                end
            end
            // A write landing in the cycle LOAD finds the buffer empty is
            // kept for the following byte; LOAD itself sends the dummy.
            if (load_en && full) begin
                full <= 1'b0;
            end else if (tx_wr) begin
                full <= 1'b1;
            end
        end
    end

    // ---- Stage 1: shift registers and TX buffer storage ----
    always_ff @(posedge clk) begin
        if (tx_wr) begin
            tx_buf <= tx_data;
        end
        if (load_en) begin
            tx_shift <= full ? tx_buf : DUMMY_BYTE;
        end else if (shift_fall && bit_cnt != 3'd0) begin
            tx_shift <= {tx_shift[6:0], 1'b0};
        end
        if (shift_rise) begin
            rx_shift <= {rx_shift[6:0], mosi_s};
        end
    end

`ifdef SPI_SLAVE_FRAME_ERR_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            frame_err   <= 1'b0;
            tx_underrun <= 1'b0;
        end else begin
            frame_err   <= ss_rise && (bit_cnt != 3'd0);
            tx_underrun <= load_en && !full;
        end
    end
`endif

endmodule

// File: tb/tb_spi_slave_byte_if.sv
module tb_spi_slave_byte_if;

    localparam int         HP    = 8;
    localparam logic [7:0] DUMMY = 8'hFF;

    logic       clk = 1'b0;
    logic       rst, sclk, mosi, ss_n, miso;
    logic [7:0] tx_data, rx_data;
    logic       tx_valid, tx_ready, rx_done, busy;
`ifdef SPI_SLAVE_FRAME_ERR_EN
    logic       frame_err, tx_underrun;
`endif

    spi_slave_byte_if #(.SYNC_STAGES(2), .DUMMY_BYTE(DUMMY)) dut (
        .clk(clk), .rst(rst), .sclk(sclk), .mosi(mosi), .ss_n(ss_n),
        .miso(miso), .tx_data(tx_data), .tx_valid(tx_valid),
        .tx_ready(tx_ready), .rx_data(rx_data), .rx_done(rx_done),
        .busy(busy)
`ifdef SPI_SLAVE_FRAME_ERR_EN
        , .frame_err(frame_err), .tx_underrun(tx_underrun)
`endif
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_pass   = 0;

    // Reference model: buffer contents, expected byte streams, event counts.
    logic [7:0] buf_q[$];
    logic [7:0] exp_rx[$];
    logic [7:0] exp_miso[$];
    logic [7:0] last_rx = 8'h00;
    int exp_underrun = 0, exp_ferr = 0, got_underrun = 0, got_ferr = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    endtask

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    // Each byte start takes the buffered byte if any, else the dummy.
    function automatic logic [7:0] byte_start();
        if (buf_q.size() > 0) return buf_q.pop_front();
        exp_underrun++;
        return DUMMY;
    endfunction

    // RX monitor: pops the expected byte whenever rx_done is presented.
    logic rx_prev = 1'b0;
    always @(negedge clk) begin
        if (rst) begin
            rx_prev = 1'b0;
        end else begin
            if (rx_done) begin
                check("rx_done_single", rx_prev, 0);
                if (exp_rx.size() == 0) check("rx_unexpected", 1, 0);
                else check("rx_data", rx_data, exp_rx.pop_front());
            end
            rx_prev = rx_done;
`ifdef SPI_SLAVE_FRAME_ERR_EN
            if (frame_err) got_ferr++;
            if (tx_underrun) got_underrun++;
`endif
        end
    end

    // MISO monitor: the master samples on SCLK rise; a full byte pops one.
    int         mbits = 0;
    logic [7:0] mbyte = 8'h00;
    always @(posedge sclk or posedge ss_n) begin
        if (ss_n) begin
            mbits = 0;
        end else begin
            mbyte = {mbyte[6:0], miso};
            mbits++;
            if (mbits == 8) begin
                mbits = 0;
                if (exp_miso.size() == 0) check("miso_unexpected", 1, 0);
                else check("miso_byte", mbyte, exp_miso.pop_front());
            end
        end
    end

    task automatic write_tx(input logic [7:0] b, input int hold);
        check("tx_ready_before_wr", tx_ready, buf_q.size() == 0);
        tx_data  = b;
        tx_valid = 1'b1;
        tick(hold);
        tx_valid = 1'b0;
        if (buf_q.size() == 0) buf_q.push_back(b);
        check("tx_ready_after_wr", tx_ready, 0);
    endtask

    task automatic spi_bits(input logic [7:0] mo, input int nbits, input bit wr, input logic [7:0] wb);
        logic [7:0] e;
        e = byte_start();
        if (nbits == 8) begin
            exp_miso.push_back(e);
            exp_rx.push_back(mo);
            last_rx = mo;
        end
        for (int i = 0; i < nbits; i++) begin
            mosi = mo[7-i];
            tick(HP);
            sclk = 1'b1;
            if (wr && i == 3) begin
                write_tx(wb, 1);
                tick(HP - 1);
            end else begin
                tick(HP);
            end
            sclk = 1'b0;
        end
    endtask

    task automatic frame(input int nbytes, input logic [7:0] d [4], input int abort_bits,
                         input int wr_byte, input logic [7:0] wb);
        ss_n = 1'b0;
        tick(HP);
        check("busy_in_frame", busy, 1);
        for (int k = 0; k < nbytes; k++) spi_bits(d[k], 8, wr_byte == k, wb);
        if (abort_bits > 0) begin
            spi_bits(d[nbytes], abort_bits, 1'b0, 8'h00);
            exp_ferr++;
        end else begin
            void'(byte_start());
        end
        tick(HP);
        ss_n = 1'b1;
        tick(6);
        check("busy_after_frame", busy, 0);
        check("rx_data_after_frame", rx_data, last_rx);
        check("tx_ready_after_frame", tx_ready, buf_q.size() == 0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL timeout: simulation did not finish, passed %0d", n_pass);
        $fatal(1);
    end

    initial begin
        logic [7:0] d [4];
        rst = 1'b1; sclk = 1'b0; mosi = 1'b0; ss_n = 1'b1;
        tx_data = 8'h00; tx_valid = 1'b0;
        tick(3);
        check("rst_miso", miso, 0);
        check("rst_tx_ready", tx_ready, 1);
        check("rst_rx_data", rx_data, 8'h00);
        check("rst_rx_done", rx_done, 0);
        check("rst_busy", busy, 0);
        rst = 1'b0;
        tick(4);

        // Buffered byte sent while 3C is received.
        write_tx(8'hA5, 1);
        frame(1, '{8'h3C, 8'h00, 8'h00, 8'h00}, 0, 9, 8'h00);
        // Empty buffer: dummy byte goes out.
        frame(1, '{8'h00, 8'h00, 8'h00, 8'h00}, 0, 9, 8'h00);
        // Two bytes in one frame with a refill during the first.
        write_tx(8'hA5, 1);
        frame(2, '{8'h12, 8'h34, 8'h00, 8'h00}, 0, 0, 8'h56);
        // Aborted after 5 rises, then a clean byte.
        frame(0, '{8'hB7, 8'h00, 8'h00, 8'h00}, 5, 9, 8'h00);
        frame(1, '{8'hC3, 8'h00, 8'h00, 8'h00}, 0, 9, 8'h00);

        // Reset in the middle of a byte.
        ss_n = 1'b0;
        tick(HP);
        spi_bits(8'h5A, 4, 1'b0, 8'h00);
        rst = 1'b1;
        ss_n = 1'b1;
        tick(1);
        rst = 1'b0;
        buf_q.delete();
        last_rx = 8'h00;
        check("midrst_miso", miso, 0);
        check("midrst_tx_ready", tx_ready, 1);
        check("midrst_rx_data", rx_data, 8'h00);
        check("midrst_rx_done", rx_done, 0);
        check("midrst_busy", busy, 0);
        tick(4);
        frame(1, '{8'h81, 8'h00, 8'h00, 8'h00}, 0, 9, 8'h00);

        // Write held while the buffer is full: only one 77 goes out.
        write_tx(8'h77, 5);
        frame(2, '{8'hAA, 8'h55, 8'h00, 8'h00}, 0, 9, 8'h00);

        // Randomised frames.
        for (int f = 0; f < 10; f++) begin
            int nb, ab, wi;
            nb = $urandom_range(1, 3);
            for (int k = 0; k < 4; k++) d[k] = 8'($urandom);
            ab = ($urandom_range(0, 3) == 0) ? $urandom_range(1, 7) : 0;
            wi = $urandom_range(0, 3);
            if ($urandom_range(0, 1) == 1) write_tx(8'($urandom), 1);
            frame(nb, d, ab, wi, 8'($urandom));
            tick($urandom_range(2, 10));
        end

        tick(10);
        check("rx_queue_drained", exp_rx.size(), 0);
        check("miso_queue_drained", exp_miso.size(), 0);
`ifdef SPI_SLAVE_FRAME_ERR_EN
        check("frame_err_count", got_ferr, exp_ferr);
        check("tx_underrun_count", got_underrun, exp_underrun);
`endif
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
